// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  // Clocks per oversample tick; integer division, truncated.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, realigned by restart.
module uart_baud_tick #(
  parameter int DIV = 423
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority vote, error flags and valid/ready output.
// Optional break detection (break_det port) when UART_RX_BREAK_DET_EN is defined.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 65_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LO   = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_HI   = SW'(M + 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP       = (STOP_BITS == 2);
  localparam logic ODD_PAR         = (PARITY == int'(PAR_ODD));

  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx_param: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < int'(PAR_NONE) || PARITY > int'(PAR_EVEN)) begin : g_bad_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_param: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end

  logic                 rxd_meta, rxd_s, rxd_s_d;
  logic                 armed;
  logic [SW-1:0]        arm_cnt;
  rx_state_t            state;
  logic [SW-1:0]        s_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, ferr, commit_pend;
  logic                 tick, start_edge, decide, bit_end, vote, is_break;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_s_d  <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_s_d  <= rxd_s;
    end
  end

  assign start_edge = (state == S_IDLE) && armed && rxd_s_d && !rxd_s;
  assign decide     = tick && (s_cnt == S_HI);
  assign bit_end    = tick && (s_cnt == S_LAST);
  assign vote       = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_edge),
    .tick    (tick)
  );

  // Arming needs one full bit time of idle-high, so a reset mid-frame cannot
  // mistake a data bit edge for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!rxd_s) begin
      arm_cnt <= '0;
    end else if (tick && !armed) begin
      if (arm_cnt == S_LAST) armed <= 1'b1;
      else                   arm_cnt <= arm_cnt + SW'(1);
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_zero  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= decide && (state == S_STOP) && (stop_idx == LAST_STOP) && is_break;
      if (start_edge) all_zero <= 1'b1;
      else if (decide && vote && state != S_IDLE) all_zero <= 1'b0;
    end
  end
  assign is_break = all_zero && !vote;
`else
  assign is_break = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      s_cnt       <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      samp        <= '0;
      shreg       <= '0;
      par_bad     <= 1'b0;
      ferr        <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      if (start_edge)                s_cnt <= '0;
      else if (tick && state != S_IDLE) s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
      if (tick && s_cnt == S_LO)  samp[0] <= rxd_s;
      if (tick && s_cnt == S_MID) samp[1] <= rxd_s;
      case (state)
        S_IDLE: if (start_edge) begin
          state    <= S_START;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par_bad  <= 1'b0;
          ferr     <= 1'b0;
        end
        S_START: begin
          if (decide && vote) state <= S_IDLE;
          else if (bit_end)   state <= S_DATA;
        end
        S_DATA: begin
          if (decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == LAST_BIT) state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                     bit_idx <= bit_idx + 4'd1;
          end
        end
        S_PARITY: begin
          if (decide)  par_bad <= (vote != (^shreg ^ ODD_PAR));
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          if (decide) begin
            ferr <= ferr | ~vote;
            if (stop_idx == LAST_STOP) begin
              if (is_break) begin
                state <= S_BRK_WAIT;
              end else begin
                commit_pend <= 1'b1;
                state       <= S_IDLE;
              end
            end
          end else if (bit_end) begin
            stop_idx <= 1'b1;
          end
        end
        S_BRK_WAIT: if (rxd_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid/ready: a frame transfers on a cycle with rx_valid && rx_ready; outputs
  // hold while rx_valid && !rx_ready; a new commit always overwrites, and flags
  // overrun only when the old frame was not being consumed in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_pend) begin
      rx_data    <= shreg;
      frame_err  <= ferr;
      parity_err <= par_bad;
      overrun    <= rx_valid && !rx_ready;
      rx_valid   <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (OVERSAMPLE 16) and a 7E2 instance (OVERSAMPLE 8).
module tb_uart_rx_param;
  localparam int CLK_HZ = 1_000_000;
  localparam int BT_A   = 64;  // clocks per bit: 1 MHz / 15625 baud
  localparam int BT_B   = 32;  // clocks per bit: 1 MHz / 31250 baud

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1, ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, ferr_a, perr_a, ovr_a;
  logic       valid_b, ferr_b, perr_b, ovr_b;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_a, brk_b;
  int         brk_pulses = 0;
`endif

  int          comp_cnt = 0, fail_cnt = 0;
  int          rise_a = 0, lat_a = 45;
  logic        valid_a_q = 1'b0;
  logic [11:0] exp_q_a[$], exp_q_b[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(15_625), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_a)
`endif
  );

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(31_250), .OVERSAMPLE(8),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_b)
`endif
  );

  always @(negedge clk) begin
    if (valid_a && !valid_a_q) rise_a++;
    valid_a_q = valid_a;
`ifdef UART_RX_BREAK_DET_EN
    if (brk_a) brk_pulses++;
`endif
  end

  // Reference model: {overrun, parity_err, frame_err, 0, payload}.
  function automatic logic [11:0] model_a(input logic [7:0] d, input logic stop_v, input logic ovr);
    return {ovr, 1'b0, ~stop_v, 1'b0, d};
  endfunction

  function automatic logic [11:0] model_b(input logic [6:0] d, input logic pbit,
                                          input logic s0, input logic s1);
    logic perr;
    perr = ((($countones(d) + int'(pbit)) % 2) != 0);
    return {1'b0, perr, ~(s0 & s1), 2'b00, d};
  endfunction

  function automatic logic [11:0] obs_a();
    return {ovr_a, perr_a, ferr_a, 1'b0, data_a};
  endfunction

  function automatic logic [11:0] obs_b();
    return {ovr_b, perr_b, ferr_b, 2'b00, data_b};
  endfunction

  task automatic line_a(input logic v, input int n);
    rxd_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic line_b(input logic v, input int n);
    rxd_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic head_a(input logic [7:0] d);
    line_a(1'b0, BT_A);
    for (int i = 0; i < 8; i++) line_a(d[i], BT_A);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop_v);
    head_a(d);
    line_a(stop_v, BT_A);
    rxd_a = 1'b1;
  endtask

  task automatic frame_b(input logic [6:0] d, input logic pbit, input logic s0, input logic s1);
    line_b(1'b0, BT_B);
    for (int i = 0; i < 7; i++) line_b(d[i], BT_B);
    line_b(pbit, BT_B);
    line_b(s0, BT_B);
    line_b(s1, BT_B);
    rxd_b = 1'b1;
  endtask

  task automatic consume_a;
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    comp_cnt++;
    if (valid_a !== 1'b0) begin
      fail_cnt++;
      $display("FAIL consume_a: rx_valid=%b, expected 0", valid_a);
    end
  endtask

  task automatic consume_b;
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    comp_cnt++;
    if (valid_b !== 1'b0) begin
      fail_cnt++;
      $display("FAIL consume_b: rx_valid=%b, expected 0", valid_b);
    end
  endtask

  task automatic check_a(input string name);
    logic [11:0] exp;
    exp = exp_q_a.pop_front();
    comp_cnt++;
    if (valid_a !== 1'b1 || obs_a() !== exp) begin
      fail_cnt++;
      $display("FAIL %s: valid=%b frame=%h, expected valid=1 frame=%h", name, valid_a, obs_a(), exp);
    end
  endtask

  task automatic check_b(input string name);
    logic [11:0] exp;
    exp = exp_q_b.pop_front();
    comp_cnt++;
    if (valid_b !== 1'b1 || obs_b() !== exp) begin
      fail_cnt++;
      $display("FAIL %s: valid=%b frame=%h, expected valid=1 frame=%h", name, valid_b, obs_b(), exp);
    end
  endtask

  task automatic test_reset;
    comp_cnt++;
    if ({valid_a, data_a, ferr_a, perr_a, ovr_a} !== 12'h000) begin
      fail_cnt++;
      $display("FAIL reset_a: outputs=%h, expected 000", {valid_a, data_a, ferr_a, perr_a, ovr_a});
    end
    comp_cnt++;
    if ({valid_b, data_b, ferr_b, perr_b, ovr_b} !== 11'h000) begin
      fail_cnt++;
      $display("FAIL reset_b: outputs=%h, expected 000", {valid_b, data_b, ferr_b, perr_b, ovr_b});
    end
`ifdef UART_RX_BREAK_DET_EN
    comp_cnt++;
    if ({brk_a, brk_b} !== 2'b00) begin
      fail_cnt++;
      $display("FAIL reset_brk: break_det=%b%b, expected 00", brk_a, brk_b);
    end
`endif
    line_a(1'b1, 2 * BT_A);
  endtask

  task automatic test_basic;
    int lat;
    exp_q_a.push_back(model_a(8'hA5, 1'b1, 1'b0));
    head_a(8'hA5);
    rxd_a = 1'b1;
    lat = 0;
    while (!valid_a && lat < 2 * BT_A) begin
      @(negedge clk);
      lat++;
    end
    lat_a = lat;
    comp_cnt++;
    if (lat < 40 || lat > 50) begin
      fail_cnt++;
      $display("FAIL basic_latency: rx_valid after %0d clk into stop bit, expected 40..50", lat);
    end
    check_a("basic_a5");
    if (lat < BT_A) line_a(1'b1, BT_A - lat);
    consume_a();
  endtask

  task automatic test_random_a;
    logic [7:0] d;
    logic       stop_v;
    for (int i = 0; i < 6; i++) begin
      d      = 8'($urandom_range(1, 255));
      stop_v = ($urandom_range(0, 3) != 0);
      exp_q_a.push_back(model_a(d, stop_v, 1'b0));
      line_a(1'b1, $urandom_range(2, BT_A));
      frame_a(d, stop_v);
      check_a("random_a");
      consume_a();
    end
  endtask

  task automatic test_parity;
    logic [6:0] d;
    logic       pbit, s0, s1;
    exp_q_b.push_back(model_b(7'h35, 1'b0, 1'b1, 1'b1));
    frame_b(7'h35, 1'b0, 1'b1, 1'b1);
    check_b("parity_good_35");
    consume_b();
    line_b(1'b1, 5);
    exp_q_b.push_back(model_b(7'h35, 1'b1, 1'b1, 1'b1));
    frame_b(7'h35, 1'b1, 1'b1, 1'b1);
    check_b("parity_bad_35");
    consume_b();
    for (int i = 0; i < 5; i++) begin
      d    = 7'($urandom_range(0, 127));
      pbit = 1'($urandom_range(0, 1));
      s0   = ($urandom_range(0, 3) != 0);
      s1   = ($urandom_range(0, 3) != 0);
      if (d == 7'd0 && !pbit && !s0) s1 = 1'b1;
      exp_q_b.push_back(model_b(d, pbit, s0, s1));
      line_b(1'b1, $urandom_range(2, BT_B));
      frame_b(d, pbit, s0, s1);
      check_b("random_b");
      consume_b();
    end
  endtask

  task automatic test_glitch_frame_err;
    int r0;
    r0 = rise_a;
    line_a(1'b0, 12);
    line_a(1'b1, 3 * BT_A);
    comp_cnt++;
    if (rise_a != r0 || valid_a !== 1'b0) begin
      fail_cnt++;
      $display("FAIL glitch_reject: frames=%0d valid=%b, expected 0 frames valid=0", rise_a - r0, valid_a);
    end
    exp_q_a.push_back(model_a(8'h3C, 1'b0, 1'b0));
    frame_a(8'h3C, 1'b0);
    check_a("frame_err_3c");
    consume_a();
    line_a(1'b1, 8);
  endtask

  task automatic test_overrun;
    ready_a = 1'b0;
    frame_a(8'h11, 1'b1);
    line_a(1'b1, 2 * BT_A);
    exp_q_a.push_back(model_a(8'h11, 1'b1, 1'b0));
    check_a("hold_11");
    frame_a(8'h22, 1'b1);
    exp_q_a.push_back(model_a(8'h22, 1'b1, 1'b1));
    check_a("overrun_22");
    line_a(1'b1, 10);
    head_a(8'h33);
    rxd_a = 1'b1;
    repeat (lat_a - 1) @(negedge clk);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    exp_q_a.push_back(model_a(8'h33, 1'b1, 1'b0));
    check_a("commit_on_handshake_33");
    line_a(1'b1, BT_A);
  endtask

  task automatic test_async_reset;
    int r0;
    head_a(8'h55);
    rxd_a = 1'b1;
    line_a(1'b0, BT_A);
    line_a(1'b1, 3 * BT_A);
    rxd_a = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    comp_cnt++;
    if ({valid_a, data_a, ferr_a, perr_a, ovr_a} !== 12'h000) begin
      fail_cnt++;
      $display("FAIL async_reset: outputs=%h, expected 000", {valid_a, data_a, ferr_a, perr_a, ovr_a});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r0 = rise_a;
    line_a(1'b0, 4 * BT_A);
    line_a(1'b1, 2 * BT_A);
    comp_cnt++;
    if (rise_a != r0 || valid_a !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_no_partial: frames=%0d valid=%b, expected 0 frames valid=0", rise_a - r0, valid_a);
    end
    exp_q_a.push_back(model_a(8'h5A, 1'b1, 1'b0));
    frame_a(8'h5A, 1'b1);
    check_a("after_reset_5a");
    consume_a();
  endtask

  task automatic test_break;
    int r0;
    r0 = rise_a;
    ready_a = 1'b0;
    line_a(1'b1, 8);
`ifdef UART_RX_BREAK_DET_EN
    begin
      int b0;
      b0 = brk_pulses;
      line_a(1'b0, 12 * BT_A);
      line_a(1'b1, 2 * BT_A);
      comp_cnt++;
      if (brk_pulses - b0 != 1 || rise_a != r0 || valid_a !== 1'b0) begin
        fail_cnt++;
        $display("FAIL break_det: pulses=%0d frames=%0d valid=%b, expected 1 pulse 0 frames valid=0",
                 brk_pulses - b0, rise_a - r0, valid_a);
      end
    end
`else
    line_a(1'b0, 12 * BT_A);
    comp_cnt++;
    if (rise_a - r0 != 1) begin
      fail_cnt++;
      $display("FAIL all_zero_count: frames=%0d, expected 1", rise_a - r0);
    end
    exp_q_a.push_back(model_a(8'h00, 1'b0, 1'b0));
    check_a("all_zero_frame");
    line_a(1'b1, 2 * BT_A);
    consume_a();
`endif
    exp_q_a.push_back(model_a(8'h01, 1'b1, 1'b0));
    frame_a(8'h01, 1'b1);
    check_a("after_break_01");
    consume_a();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_random_a();
    test_parity();
    test_glitch_frame_err();
    test_overrun();
    test_async_reset();
    test_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    fail_cnt++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
    $fatal(1, "timeout");
  end

endmodule
